// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops land in the output register on accept; MUL/MULH iterate shift-add over WIDTH cycles.
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       exec_cmd,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_res,
  output logic             C_out,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_mulh;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_res;
  logic                 r_c, r_v, r_z, r_n;

  logic                 w_out_free;
  logic                 w_accept;
  logic                 w_is_mul;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c, w_v;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mul_res;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = rst_n && (r_state == S_IDLE) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = MUL_EN && ((exec_cmd == 4'b1010) || (exec_cmd == 4'b1011));

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (exec_cmd)
      4'b0001: w_res = val2;
      4'b1001: w_res = ~val2;
      4'b0010, 4'b0011: begin
        w_sum = {1'b0, val1} + {1'b0, val2} + {{WIDTH{1'b0}}, exec_cmd[0] & C_in};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (val1[WIDTH-1] == val2[WIDTH-1]) && (w_sum[WIDTH-1] != val1[WIDTH-1]);
      end
      4'b0100, 4'b0101: begin
        // SUB adds the +1 of two's complement; SBC substitutes the incoming carry
        w_sum = {1'b0, val1} + {1'b0, ~val2} + {{WIDTH{1'b0}}, exec_cmd[0] ? C_in : 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (val1[WIDTH-1] != val2[WIDTH-1]) && (w_sum[WIDTH-1] != val1[WIDTH-1]);
      end
      4'b0110: w_res = val1 & val2;
      4'b0111: w_res = val1 | val2;
      4'b1000: w_res = val1 ^ val2;
      default: w_res = '0;
    endcase
  end

  // Once the multiplier has shifted out, further steps add nothing, so a stalled
  // completion can keep stepping without disturbing the accumulator.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res  = r_mulh ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
    end else begin
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, val1};
              r_mplier <= val2;
              r_mulh   <= exec_cmd[0];
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end else begin
              r_out_valid <= 1'b1;
              r_res       <= w_res;
              r_c         <= w_c;
              r_v         <= w_v;
              r_z         <= (w_res == '0);
              r_n         <= w_res[WIDTH-1];
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == CW'(WIDTH-1)) begin
            if (w_out_free) begin
              r_out_valid <= 1'b1;
              r_res       <= w_mul_res;
              r_c         <= 1'b0;
              r_v         <= 1'b0;
              r_z         <= (w_mul_res == '0);
              r_n         <= w_mul_res[WIDTH-1];
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign ALU_res   = r_res;
  assign C_out     = r_c;
  assign V         = r_v;
  assign Z         = r_z;
  assign N         = r_n;

endmodule
